// File: rtl/data_end_rule_checker.sv
// data_end_rule_checker: per-channel monitor for the PCI data-end rule
// (antecedent, then rose(frame) within [MIN_DLY:MAX_DLY], then rose(irdy) GAP samples later).
module data_end_rule_checker #(
    parameter int NUM_CH  = 1,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 2,
    parameter int GAP     = 1,
    parameter int CNT_W   = 8
) (
    input  logic                      mclk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         data_phase,
    input  logic [NUM_CH-1:0]         frame,
    input  logic [NUM_CH-1:0]         irdy,
    input  logic [NUM_CH-1:0]         trdy,
    input  logic [NUM_CH-1:0]         stop,
    output logic [NUM_CH-1:0]         pass_o,
    output logic [NUM_CH-1:0]         fail_o,
    output logic [NUM_CH-1:0]         overlap_o,
    output logic [NUM_CH-1:0]         busy_o,
    output logic [NUM_CH*CNT_W-1:0]   fail_cnt_o
);
    localparam int DW = $clog2(MAX_DLY + GAP + 1);
    localparam logic [DW-1:0] DLY_SAT = DW'(MAX_DLY + GAP);
    localparam logic [DW-1:0] DLY_MIN = DW'(MIN_DLY);
    localparam logic [DW-1:0] DLY_MAX = DW'(MAX_DLY);
    typedef enum logic {IDLE, ACTIVE} state_e;
    logic [NUM_CH-1:0] frame_q, irdy_q, trdy_q, stop_q, rose_frame, rose_irdy, ante;
    logic primed_q;
    // No edge is trusted until one real sample has been captured after reset.
    assign rose_frame = frame & ~frame_q & {NUM_CH{primed_q}};
    assign rose_irdy  = irdy & ~irdy_q & {NUM_CH{primed_q}};
    assign ante = {NUM_CH{en & primed_q}} & data_phase & ~irdy & ((~trdy & trdy_q) | (~stop & stop_q));
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            frame_q  <= '0;
            irdy_q   <= '0;
            trdy_q   <= '0;
            stop_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            frame_q  <= frame;
            irdy_q   <= irdy;
            trdy_q   <= trdy;
            stop_q   <= stop;
            primed_q <= 1'b1;
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e state_q, state_d;
        logic [DW-1:0] dly_q, dly_d, dly_inc;
        logic [GAP-1:0] pend_q, pend_d;
        logic [GAP:0] sh;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic enter, pass, fail, pass_q, fail_q, ovl_q, pass_d, fail_d, ovl_d;
        // sh[GAP] is the frame candidate maturing this sample; sh[GAP-1:0] is what stays pending.
        always_comb begin
            dly_inc = (dly_q == DLY_SAT) ? dly_q : dly_q + 1'b1;
            enter   = rose_frame[c] && dly_inc >= DLY_MIN && dly_inc <= DLY_MAX;
            sh      = {pend_q, enter};
            pass    = sh[GAP] && rose_irdy[c];
            fail    = dly_inc >= DLY_MAX && !pass && sh[GAP-1:0] == '0;
            state_d = state_q;
            dly_d   = dly_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            ovl_d   = 1'b0;
            if (!en) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = ante[c] ? ACTIVE : IDLE;
                dly_d   = '0;
                pend_d  = '0;
            end else begin
                dly_d  = dly_inc;
                pend_d = sh[GAP-1:0];
                pass_d = pass;
                fail_d = fail;
                cnt_d  = (fail && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
                if (pass || fail) begin
                    state_d = ante[c] ? ACTIVE : IDLE;
                    dly_d   = '0;
                    pend_d  = '0;
                end else begin
                    ovl_d = ante[c];
                end
            end
        end
        always_ff @(posedge mclk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                dly_q   <= '0;
                pend_q  <= '0;
                cnt_q   <= '0;
                pass_q  <= 1'b0;
                fail_q  <= 1'b0;
                ovl_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dly_q   <= dly_d;
                pend_q  <= pend_d;
                cnt_q   <= cnt_d;
                pass_q  <= pass_d;
                fail_q  <= fail_d;
                ovl_q   <= ovl_d;
            end
        end
        assign pass_o[c]    = pass_q;
        assign fail_o[c]    = fail_q;
        assign overlap_o[c] = ovl_q;
        assign busy_o[c]    = state_q == ACTIVE;
        assign fail_cnt_o[c*CNT_W +: CNT_W] = cnt_q;
    end
endmodule

// File: tb/tb_data_end_rule_checker.sv
// tb_data_end_rule_checker: directed plus random stimulus against a history-based model of the rule.
module tb_data_end_rule_checker;
    localparam int NCH = 2;
    localparam int MIN = 1;
    localparam int MAX = 2;
    localparam int GP  = 1;
    localparam int CW  = 2;
    logic mclk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [NCH-1:0] dp = '0, fr = '0, ir = '0, tr = '0, st = '0;
    logic [NCH-1:0] pass_o, fail_o, overlap_o, busy_o;
    logic [NCH*CW-1:0] fail_cnt_o;
    int checks = 0, errors = 0, n = 0;
    bit rf_h [NCH][4096];
    bit m_primed;
    logic [NCH-1:0] p_fr, p_ir, p_tr, p_st, e_pass, e_fail, e_ovl;
    bit act [NCH];
    int t0 [NCH];
    int cnt [NCH];
    always #5 mclk = ~mclk;
    data_end_rule_checker #(.NUM_CH(NCH), .MIN_DLY(MIN), .MAX_DLY(MAX), .GAP(GP), .CNT_W(CW)) dut (
        .mclk(mclk), .rst(rst), .en(en), .data_phase(dp), .frame(fr), .irdy(ir), .trdy(tr), .stop(st),
        .pass_o(pass_o), .fail_o(fail_o), .overlap_o(overlap_o), .busy_o(busy_o), .fail_cnt_o(fail_cnt_o)
    );
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, a, e);
        end
    endtask
    task automatic model_reset();
        m_primed = 0;
        {p_fr, p_ir, p_tr, p_st, e_pass, e_fail, e_ovl} = '0;
        for (int c = 0; c < NCH; c++) begin
            act[c] = 0;
            cnt[c] = 0;
        end
    endtask
    // A verdict is decided by scanning the recorded frame edges of the attempt's window.
    task automatic model_step();
        logic [NCH-1:0] rfr, rir, a;
        bit p, pend, fl;
        rfr = m_primed ? (fr & ~p_fr) : '0;
        rir = m_primed ? (ir & ~p_ir) : '0;
        a = (en && m_primed) ? (dp & ~ir & ((~tr & p_tr) | (~st & p_st))) : '0;
        e_pass = '0;
        e_fail = '0;
        e_ovl = '0;
        for (int c = 0; c < NCH; c++) begin
            rf_h[c][n] = rfr[c];
            if (!en) act[c] = 0;
            else if (!act[c]) begin
                if (a[c]) begin
                    act[c] = 1;
                    t0[c] = n;
                end
            end else begin
                p = 0;
                pend = 0;
                for (int f = t0[c] + MIN; f <= t0[c] + MAX && f <= n; f++)
                    if (rf_h[c][f]) begin
                        if (f + GP == n && rir[c]) p = 1;
                        if (f + GP > n) pend = 1;
                    end
                fl = !p && n >= t0[c] + MAX && !pend;
                e_pass[c] = p;
                e_fail[c] = fl;
                if (p || fl) begin
                    if (fl && cnt[c] < (1 << CW) - 1) cnt[c]++;
                    act[c] = a[c];
                    t0[c] = n;
                end else e_ovl[c] = a[c];
            end
        end
        {p_fr, p_ir, p_tr, p_st} = {fr, ir, tr, st};
        m_primed = 1;
        n++;
    endtask
    task automatic compare();
        logic [NCH-1:0] eb;
        logic [NCH*CW-1:0] ec;
        for (int c = 0; c < NCH; c++) begin
            eb[c] = act[c];
            ec[c*CW +: CW] = CW'(cnt[c]);
        end
        chk("pass", 32'(pass_o), 32'(e_pass));
        chk("fail", 32'(fail_o), 32'(e_fail));
        chk("overlap", 32'(overlap_o), 32'(e_ovl));
        chk("busy", 32'(busy_o), 32'(eb));
        chk("fail_cnt", 32'(fail_cnt_o), 32'(ec));
    endtask
    task automatic cyc(input logic e, input logic [NCH-1:0] d, f, i, t, s);
        @(negedge mclk);
        en = e;
        dp = d;
        fr = f;
        ir = i;
        tr = t;
        st = s;
        @(posedge mclk);
        model_step();
        #1 compare();
    endtask
    task automatic pulse_reset();
        @(negedge mclk);
        #2 rst = 1'b1;
        model_reset();
        #1 compare();
        chk("rst_async_busy", 32'(busy_o), 32'h0);
        @(posedge mclk);
        #1 rst = 1'b0;
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge mclk);
        #1 compare();
        chk("reset_cnt", 32'(fail_cnt_o), 32'h0);
        rst = 1'b0;
        cyc(1, 3, 0, 0, 3, 0);
        cyc(1, 3, 0, 0, 0, 0);
        chk("ante_busy", 32'(busy_o), 32'h3);
        cyc(1, 3, 1, 0, 0, 0);
        cyc(1, 3, 1, 1, 0, 0);
        chk("ch0_pass", 32'(pass_o), 32'h1);
        chk("ch1_fail", 32'(fail_o), 32'h2);
        chk("cnt_first", 32'(fail_cnt_o), 32'h4);
        cyc(1, 3, 0, 0, 3, 3);
        chk("pulse_once", 32'(pass_o | fail_o), 32'h0);
        cyc(1, 3, 0, 0, 0, 3);
        cyc(1, 3, 0, 0, 0, 0);
        chk("overlap", 32'(overlap_o), 32'h3);
        cyc(1, 3, 0, 0, 0, 0);
        chk("ovl_single_fail", 32'(fail_o), 32'h3);
        chk("cnt_after_ovl", 32'(fail_cnt_o), 32'h9);
        repeat (2) begin
            cyc(1, 3, 0, 0, 3, 0);
            cyc(1, 3, 0, 0, 0, 0);
            cyc(1, 3, 0, 0, 0, 0);
            cyc(1, 3, 0, 0, 0, 0);
        end
        chk("cnt_saturate", 32'(fail_cnt_o), 32'hf);
        cyc(1, 3, 0, 0, 3, 3);
        cyc(1, 3, 0, 0, 0, 3);
        cyc(1, 3, 0, 0, 0, 3);
        cyc(1, 3, 0, 0, 0, 0);
        chk("verdict_restart_fail", 32'(fail_o), 32'h3);
        chk("verdict_restart_busy", 32'(busy_o), 32'h3);
        chk("verdict_restart_ovl", 32'(overlap_o), 32'h0);
        cyc(1, 3, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0);
        chk("cnt_hold", 32'(fail_cnt_o), 32'hf);
        cyc(1, 3, 0, 0, 3, 0);
        cyc(1, 3, 0, 0, 0, 0);
        cyc(0, 3, 0, 0, 0, 0);
        chk("en_abort", 32'(busy_o), 32'h0);
        cyc(1, 3, 0, 0, 0, 0);
        chk("en_no_verdict", 32'(fail_o), 32'h0);
        cyc(1, 3, 0, 0, 3, 0);
        cyc(1, 3, 0, 0, 0, 0);
        pulse_reset();
        chk("rst_cnt", 32'(fail_cnt_o), 32'h0);
        cyc(1, 3, 1, 1, 0, 0);
        chk("rst_no_verdict", 32'(pass_o | fail_o), 32'h0);
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(199) == 0) pulse_reset();
            else cyc($urandom_range(39) != 0, NCH'($urandom_range(7) != 0 ? 3 : $urandom_range(3)),
                     NCH'($urandom), NCH'($urandom_range(2) == 0 ? $urandom : 0),
                     NCH'($urandom), NCH'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
